// File: rtl/chunk_word_streamer_pkg.sv
// rtl/chunk_word_streamer_pkg.sv - local-memory chunk/word geometry shared by controller, streamer and datapath
package chunk_word_streamer_pkg;

   localparam int NUM_BITS  = 512;
   localparam int WORD_BITS = 32;
   localparam int NUM_WORDS = NUM_BITS / WORD_BITS;

   // Width of a word index within a chunk; never narrower than one bit.
   function automatic int idx_width(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

   localparam int IDX_BITS = idx_width(NUM_WORDS);

endpackage

// File: rtl/chunk_word_sel.sv
// rtl/chunk_word_sel.sv - combinational word select from a chunk, LSB word first
module chunk_word_sel
   import chunk_word_streamer_pkg::*;
#(
   parameter int num_bits  = NUM_BITS,
   parameter int word_bits = WORD_BITS,
   parameter int idx_bits  = IDX_BITS
) (
   input  logic [num_bits-1:0]  chunk,
   input  logic [idx_bits-1:0]  idx,
   output logic [word_bits-1:0] word
);

   assign word = chunk[int'(idx)*word_bits +: word_bits];

endmodule

// File: rtl/chunk_word_streamer.sv
// rtl/chunk_word_streamer.sv - double-buffered chunk to word stream converter
module chunk_word_streamer
   import chunk_word_streamer_pkg::*;
#(
   parameter  int num_bits  = NUM_BITS,
   parameter  int word_bits = WORD_BITS,
   localparam int num_words = num_bits / word_bits,
   localparam int idx_bits  = idx_width(num_words)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [num_bits-1:0]  chunk_in,
   input  logic                 chunk_valid,
   output logic                 chunk_ready,
   output logic [word_bits-1:0] word_out,
   output logic                 word_valid,
   input  logic                 word_ready,
   output logic                 word_last,
   output logic [idx_bits-1:0]  word_idx,
   output logic                 busy
);

   if ((num_bits % word_bits) != 0 || num_words < 2) begin : g_bad_geometry
      $fatal(1, "chunk_word_streamer: num_bits must be a multiple of word_bits with at least two words");
   end

   logic [num_bits-1:0]  active_buf;
   logic [num_bits-1:0]  pending_buf;
   logic                 active_full;
   logic                 pending_full;
   logic [idx_bits-1:0]  idx;
   logic [word_bits-1:0] sel_word;

   logic at_last;
   logic accept;
   logic xfer;
   logic word_release;
   logic load_active;

   assign at_last      = (idx == idx_bits'(num_words - 1));
   assign chunk_ready  = !pending_full;
   assign accept       = chunk_valid & chunk_ready;
   assign word_valid   = active_full;
   assign xfer         = word_valid & word_ready;
   assign word_release = xfer & at_last;
   // A new chunk goes straight to active when active is free now or frees on this edge.
   assign load_active  = !active_full || (word_release && !pending_full);

   assign word_last = active_full & at_last;
   assign word_idx  = idx;
   assign busy      = active_full | pending_full;
   assign word_out  = active_full ? sel_word : '0;

   chunk_word_sel #(
      .num_bits  (num_bits),
      .word_bits (word_bits),
      .idx_bits  (idx_bits)
   ) u_sel (
      .chunk (active_buf),
      .idx   (idx),
      .word  (sel_word)
   );

   // Slot occupancy flags and word index; reset discards both slots.
   always_ff @(posedge clk) begin
      if (rst) begin
         active_full  <= 1'b0;
         pending_full <= 1'b0;
         idx          <= '0;
      end else begin
         if (word_release) begin
            idx <= '0;
            if (pending_full) begin
               pending_full <= 1'b0;
            end else begin
               active_full <= 1'b0;
            end
         end else if (xfer) begin
            idx <= idx + idx_bits'(1);
         end
         if (accept) begin
            if (load_active) begin
               active_full <= 1'b1;
               idx         <= '0;
            end else begin
               pending_full <= 1'b1;
            end
         end
      end
   end

   // Slot data: pending promotes on release, accepts load the slot chosen above.
   always_ff @(posedge clk) begin
      if (word_release && pending_full) begin
         active_buf <= pending_buf;
      end
      if (accept) begin
         if (load_active) begin
            active_buf <= chunk_in;
         end else begin
            pending_buf <= chunk_in;
         end
      end
   end

endmodule

// File: tb/tb_chunk_word_streamer.sv
// tb/tb_chunk_word_streamer.sv - directed vector bench for chunk_word_streamer
module tb_chunk_word_streamer;

   localparam int NB = 512;
   localparam int WB = 32;
   localparam int NW = 16;

   typedef struct {
      logic        r;
      logic        cv;
      logic [3:0]  cn;
      logic        wr;
      logic        e_cr;
      logic        e_wv;
      logic [31:0] e_wo;
      logic [3:0]  e_idx;
      logic        e_last;
      logic        e_busy;
   } vec_t;

   logic          clk;
   logic          rst;
   logic [NB-1:0] chunk_in;
   logic          chunk_valid;
   logic          chunk_ready;
   logic [WB-1:0] word_out;
   logic          word_valid;
   logic          word_ready;
   logic          word_last;
   logic [3:0]    word_idx;
   logic          busy;

   int pass_cnt = 0;
   int total_cnt = 0;
   vec_t tbl[$];

   chunk_word_streamer dut (
      .clk         (clk),
      .rst         (rst),
      .chunk_in    (chunk_in),
      .chunk_valid (chunk_valid),
      .chunk_ready (chunk_ready),
      .word_out    (word_out),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .word_last   (word_last),
      .word_idx    (word_idx),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [NB-1:0] mk(input logic [3:0] n);
      logic [NB-1:0] c;
      for (int k = 0; k < NW; k++) c[k*WB +: WB] = {n, 28'h0} + 32'(k);
      return c;
   endfunction

   function automatic logic [31:0] wd(input logic [3:0] n, input int k);
      return {n, 28'h0} + 32'(k);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic chk_all(input string tag, input logic cr, input logic wv, input logic [31:0] wo,
                          input logic [3:0] ix, input logic last, input logic bz);
      chk({tag, ".chunk_ready"}, 64'(chunk_ready), 64'(cr));
      chk({tag, ".word_valid"},  64'(word_valid),  64'(wv));
      chk({tag, ".word_out"},    64'(word_out),    64'(wo));
      chk({tag, ".word_idx"},    64'(word_idx),    64'(ix));
      chk({tag, ".word_last"},   64'(word_last),   64'(last));
      chk({tag, ".busy"},        64'(busy),        64'(bz));
   endtask

   task automatic drive(input logic r, input logic cv, input logic [3:0] cn, input logic wr);
      rst = r;
      chunk_valid = cv;
      chunk_in = mk(cv ? cn : 4'hE);
      word_ready = wr;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic cv, input logic [3:0] cn, input logic wr,
                      input logic cr, input logic wv, input logic [31:0] wo, input logic [3:0] ix,
                      input logic last, input logic bz);
      vec_t v;
      v.r = r; v.cv = cv; v.cn = cn; v.wr = wr;
      v.e_cr = cr; v.e_wv = wv; v.e_wo = wo; v.e_idx = ix; v.e_last = last; v.e_busy = bz;
      tbl.push_back(v);
   endtask

   // Idle cycle, optionally offering a chunk.
   task automatic add_idle(input logic cv, input logic [3:0] cn);
      add(1'b0, cv, cn, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
   endtask

   // Words first..last of chunk wn streamed with word_ready=1.
   task automatic add_words(input logic [3:0] wn, input int first, input int last,
                            input logic cv, input logic [3:0] cn, input logic cr);
      for (int k = first; k <= last; k++)
         add(1'b0, cv, cn, 1'b1, cr, 1'b1, wd(wn, k), 4'(k), k == NW - 1, 1'b1);
   endtask

   initial begin
      int exp_k;
      int cyc;
      logic [3:0] patt;

      // Reset held two cycles with a chunk offered: nothing accepted.
      add(1'b1, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      add_idle(1'b1, 4'hA);
      // Single chunk A: words on cycles 1..16, idle after.
      add_words(4'hA, 0, 15, 1'b0, 4'h0, 1'b1);
      add_idle(1'b0, 4'h0);
      // Back-to-back A then B with chunk_valid held.
      add_idle(1'b1, 4'hA);
      add_words(4'hA, 0, 0, 1'b1, 4'hB, 1'b1);
      add_words(4'hA, 1, 15, 1'b1, 4'hB, 1'b0);
      add_words(4'hB, 0, 15, 1'b0, 4'h0, 1'b1);
      add_idle(1'b0, 4'h0);
      // Accept coinciding with release, pending empty.
      add_idle(1'b1, 4'hA);
      add_words(4'hA, 0, 14, 1'b0, 4'h0, 1'b1);
      add_words(4'hA, 15, 15, 1'b1, 4'hC, 1'b1);
      add_words(4'hC, 0, 15, 1'b0, 4'h0, 1'b1);
      add_idle(1'b0, 4'h0);

      drive(1'b1, 1'b1, 4'hA, 1'b1);
      tick();
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].r, tbl[i].cv, tbl[i].cn, tbl[i].wr);
         chk_all($sformatf("vec%0d", i), tbl[i].e_cr, tbl[i].e_wv, tbl[i].e_wo,
                 tbl[i].e_idx, tbl[i].e_last, tbl[i].e_busy);
         tick();
      end

      // Backpressure: ready pattern 1,0,0 repeating; words held during stalls.
      drive(1'b0, 1'b1, 4'h5, 1'b0);
      tick();
      exp_k = 0;
      cyc = 0;
      patt = 4'b0001;
      while (exp_k < NW && cyc < 200) begin
         drive(1'b0, 1'b0, 4'h0, (cyc % 3) == 0);
         chk($sformatf("bp%0d.word_valid", cyc), 64'(word_valid), 64'd1);
         chk($sformatf("bp%0d.word_out", cyc), 64'(word_out), 64'(wd(4'h5, exp_k)));
         chk($sformatf("bp%0d.word_idx", cyc), 64'(word_idx), 64'(exp_k));
         chk($sformatf("bp%0d.word_last", cyc), 64'(word_last), 64'(exp_k == NW - 1));
         if (word_ready) exp_k++;
         tick();
         cyc++;
      end
      chk("bp.completed", 64'(exp_k), 64'(NW));
      drive(1'b0, 1'b0, 4'h0, 1'b1);
      chk_all("bp.after", 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);

      // Reset mid-stream at A word 5 with B pending.
      drive(1'b0, 1'b1, 4'hA, 1'b1);
      tick();
      drive(1'b0, 1'b1, 4'hB, 1'b1);
      chk_all("mr.a0", 1'b1, 1'b1, wd(4'hA, 0), 4'h0, 1'b0, 1'b1);
      tick();
      for (int k = 1; k <= 4; k++) begin
         drive(1'b0, 1'b0, 4'h0, 1'b1);
         chk_all($sformatf("mr.a%0d", k), 1'b0, 1'b1, wd(4'hA, k), 4'(k), 1'b0, 1'b1);
         tick();
      end
      drive(1'b1, 1'b1, 4'hD, 1'b1);
      chk_all("mr.a5", 1'b0, 1'b1, wd(4'hA, 5), 4'h5, 1'b0, 1'b1);
      tick();
      drive(1'b0, 1'b1, 4'hC, 1'b1);
      chk_all("mr.post_rst", 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < NW; k++) begin
         drive(1'b0, 1'b0, 4'h0, 1'b1);
         chk_all($sformatf("mr.c%0d", k), 1'b1, 1'b1, wd(4'hC, k), 4'(k), k == NW - 1, 1'b1);
         tick();
      end
      drive(1'b0, 1'b0, 4'h0, 1'b1);
      chk_all("mr.idle", 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
